// File: rtl/sobel_magnitude_threshold_if.sv
// rtl/sobel_magnitude_threshold_if.sv - pixel-in / magnitude-out handshake bundle
// Purpose: groups the gradient input stream, the threshold, and the magnitude
//          output stream of sobel_magnitude_threshold.
// Signals:
//   in_valid/in_ready/gx_in/gy_in : gradient pair stream into the block
//   threshold                     : edge threshold, latched per frame
//   out_valid/out_ready           : output stream handshake
//   mag_out/edge_out              : saturated magnitude and edge bit
//   sof_out/eol_out/frame_done    : frame markers
// Modports: slave = the block, master = the producer/consumer side.
interface sobel_magnitude_threshold_if #(
  parameter int GW = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [GW-1:0] gx_in;
  logic signed [GW-1:0] gy_in;
  logic [7:0]           threshold;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           mag_out;
  logic                 edge_out;
  logic                 sof_out;
  logic                 eol_out;
  logic                 frame_done;

  modport slave (
    input  in_valid, gx_in, gy_in, threshold, out_ready,
    output in_ready, out_valid, mag_out, edge_out, sof_out, eol_out, frame_done
  );

  modport master (
    output in_valid, gx_in, gy_in, threshold, out_ready,
    input  in_ready, out_valid, mag_out, edge_out, sof_out, eol_out, frame_done
  );
endinterface

// File: rtl/sobel_magnitude_threshold.sv
// rtl/sobel_magnitude_threshold.sv - |Gx|+|Gy| magnitude, saturation, border mask and edge threshold
// Purpose: two-stage valid/ready pipeline taking one signed gradient pair per
//          pixel in raster order; emits an 8-bit saturated magnitude, an edge
//          bit and frame markers derived from internal row/column counters.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sobel_magnitude_threshold_if.slave (input stream, threshold,
//           output stream, sof/eol/frame_done markers)
module sobel_magnitude_threshold #(
  parameter int GW    = 10,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                           clk,
  input  logic                           rst_n,
  sobel_magnitude_threshold_if.slave     bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // position and frame threshold
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    thr_q, thr_d;

  // stage 1: raw sum plus per-pixel flags
  logic          v1_q, v1_d;
  logic [GW:0]   sum1_q, sum1_d;
  logic          border1_q, border1_d;
  logic          sof1_q, sof1_d;
  logic          eol1_q, eol1_d;
  logic          last1_q, last1_d;

  // stage 2: output register
  logic          v2_q, v2_d;
  logic [7:0]    mag2_q, mag2_d;
  logic          edge2_q, edge2_d;
  logic          sof2_q, sof2_d;
  logic          eol2_q, eol2_d;
  logic          last2_q, last2_d;

  logic          en;
  logic          accept;
  logic [GW-1:0] abs_x, abs_y;
  logic          col_first, col_last, row_first, row_last;
  logic [7:0]    sat;

  always_comb begin
    en       = !v2_q || bus.out_ready;
    accept   = bus.in_valid && en;

    // unsigned reinterpretation makes -2^(GW-1) come out as 2^(GW-1)
    abs_x    = bus.gx_in[GW-1] ? -bus.gx_in : bus.gx_in;
    abs_y    = bus.gy_in[GW-1] ? -bus.gy_in : bus.gy_in;

    col_first = (col_q == '0);
    col_last  = (col_q == COL_LAST);
    row_first = (row_q == '0);
    row_last  = (row_q == ROW_LAST);

    sat = (sum1_q > (GW+1)'(255)) ? 8'hFF : sum1_q[7:0];

    col_d     = col_q;
    row_d     = row_q;
    thr_d     = thr_q;
    v1_d      = v1_q;
    sum1_d    = sum1_q;
    border1_d = border1_q;
    sof1_d    = sof1_q;
    eol1_d    = eol1_q;
    last1_d   = last1_q;
    v2_d      = v2_q;
    mag2_d    = mag2_q;
    edge2_d   = edge2_q;
    sof2_d    = sof2_q;
    eol2_d    = eol2_q;
    last2_d   = last2_q;

    if (en) begin
      v1_d = bus.in_valid;
    end

    if (accept) begin
      sum1_d    = {1'b0, abs_x} + {1'b0, abs_y};
      border1_d = row_first || row_last || col_first || col_last;
      sof1_d    = row_first && col_first;
      eol1_d    = col_last;
      last1_d   = row_last && col_last;
      // first pixel of the frame picks up the threshold it arrives with
      if (row_first && col_first) begin
        thr_d = bus.threshold;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // stage 2 compares against thr_q, which already holds the new frame's
    // threshold by the time pixel (0,0) reaches it
    if (en) begin
      v2_d    = v1_q;
      mag2_d  = border1_q ? 8'h00 : sat;
      edge2_d = !border1_q && (sat >= thr_q);
      sof2_d  = sof1_q;
      eol2_d  = eol1_q;
      last2_d = last1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      thr_q     <= '0;
      v1_q      <= 1'b0;
      sum1_q    <= '0;
      border1_q <= 1'b0;
      sof1_q    <= 1'b0;
      eol1_q    <= 1'b0;
      last1_q   <= 1'b0;
      v2_q      <= 1'b0;
      mag2_q    <= '0;
      edge2_q   <= 1'b0;
      sof2_q    <= 1'b0;
      eol2_q    <= 1'b0;
      last2_q   <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      thr_q     <= thr_d;
      v1_q      <= v1_d;
      sum1_q    <= sum1_d;
      border1_q <= border1_d;
      sof1_q    <= sof1_d;
      eol1_q    <= eol1_d;
      last1_q   <= last1_d;
      v2_q      <= v2_d;
      mag2_q    <= mag2_d;
      edge2_q   <= edge2_d;
      sof2_q    <= sof2_d;
      eol2_q    <= eol2_d;
      last2_q   <= last2_d;
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = v2_q;
  assign bus.mag_out    = mag2_q;
  assign bus.edge_out   = edge2_q;
  assign bus.sof_out    = sof2_q;
  assign bus.eol_out    = eol2_q;
  assign bus.frame_done = v2_q && bus.out_ready && last2_q;
endmodule

// File: tb/tb_sobel_magnitude_threshold.sv
// tb/tb_sobel_magnitude_threshold.sv - scoreboard bench for sobel_magnitude_threshold
module tb_sobel_magnitude_threshold;
  localparam int GW = 10;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct {
    int mag;
    int edge_bit;
    int sof;
    int eol;
    int last;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   last_stall;
  int   fd_count;
  exp_t sb[$];

  int   pr, pc, thr_m;
  bit   prev_stall;
  int   prev_mag, prev_edge, prev_sof, prev_eol;
  bit   stim_done;

  sobel_magnitude_threshold_if #(.GW(GW)) bus ();

  sobel_magnitude_threshold #(.GW(GW), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // reference model: runs on every accepted input, pushes the expected output
  always @(negedge clk) begin
    exp_t e;
    int gxi, gyi, s, m;
    bit border;
    if (!rst_n) begin
      sb.delete();
      pr = 0;
      pc = 0;
    end else if (bus.in_valid && bus.in_ready) begin
      if (pr == 0 && pc == 0) thr_m = bus.threshold;
      gxi = $signed(bus.gx_in);
      gyi = $signed(bus.gy_in);
      s = iabs(gxi) + iabs(gyi);
      m = (s > 255) ? 255 : s;
      border = (pr == 0) || (pr == H - 1) || (pc == 0) || (pc == W - 1);
      e.mag      = border ? 0 : m;
      e.edge_bit = (!border && m >= thr_m) ? 1 : 0;
      e.sof      = (pr == 0 && pc == 0) ? 1 : 0;
      e.eol      = (pc == W - 1) ? 1 : 0;
      e.last     = (pr == H - 1 && pc == W - 1) ? 1 : 0;
      e.cyc      = cyc;
      sb.push_back(e);
      pc++;
      if (pc == W) begin
        pc = 0;
        pr++;
        if (pr == H) pr = 0;
      end
    end
  end

  // output monitor
  always @(negedge clk) begin
    exp_t e;
    bit hs;
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_mag", bus.mag_out, 0);
      chk("rst_edge", bus.edge_out, 0);
      chk("rst_sof", bus.sof_out, 0);
      chk("rst_eol", bus.eol_out, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", bus.in_ready, (!bus.out_valid || bus.out_ready) ? 1 : 0);
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_mag", bus.mag_out, prev_mag);
        chk("stall_edge", bus.edge_out, prev_edge);
        chk("stall_sof", bus.sof_out, prev_sof);
        chk("stall_eol", bus.eol_out, prev_eol);
      end
      hs = bus.out_valid && bus.out_ready;
      if (hs) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("mag", bus.mag_out, e.mag);
          chk("edge", bus.edge_out, e.edge_bit);
          chk("sof", bus.sof_out, e.sof);
          chk("eol", bus.eol_out, e.eol);
          chk("frame_done", bus.frame_done, e.last);
          if (last_stall < e.cyc) chk("latency", cyc - e.cyc, 2);
        end
        if (bus.frame_done) fd_count++;
      end else begin
        chk("frame_done_idle", bus.frame_done, 0);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      if (prev_stall) last_stall = cyc;
      prev_mag  = bus.mag_out;
      prev_edge = bus.edge_out;
      prev_sof  = bus.sof_out;
      prev_eol  = bus.eol_out;
    end
  end

  task automatic send(input logic signed [GW-1:0] x, input logic signed [GW-1:0] y);
    int n;
    bus.in_valid = 1'b1;
    bus.gx_in    = x;
    bus.gy_in    = y;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(GW'($urandom), GW'($urandom));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; last_stall = -1; fd_count = 0;
    pr = 0; pc = 0; thr_m = 0; prev_stall = 1'b0; stim_done = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.gx_in = '0; bus.gy_in = '0;
    bus.threshold = 8'd0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // nominal frame
    bus.threshold = 8'd100;
    fd_count = 0;
    for (int i = 0; i < W * H; i++) send(10'sd60, -10'sd50);
    drain();
    chk("frame_done_count", fd_count, 1);

    // saturation and extremes
    bus.threshold = 8'd1;
    for (int i = 0; i < W * H; i++) begin
      case (i)
        5:  send(-10'sd512, -10'sd512);
        6:  send(10'sd511, 10'sd0);
        9:  send(10'sd0, 10'sd0);
        10: send(10'sd5, 10'sd3);
        default: send_rand();
      endcase
    end

    // threshold boundary, mid-frame threshold change ignored
    bus.threshold = 8'd110;
    for (int i = 0; i < W * H; i++) begin
      if (i == 7) bus.threshold = 8'd0;
      case (i)
        5:  send(10'sd60, 10'sd50);
        6:  send(10'sd60, 10'sd49);
        9:  send(10'sd60, 10'sd49);
        10: send(10'sd1, 10'sd0);
        default: send_rand();
      endcase
    end
    // next frame latches threshold 0
    for (int i = 0; i < W * H; i++) begin
      if (i == 5) send(10'sd0, 10'sd0);
      else send_rand();
    end
    drain();

    // backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand();
      end
      begin
        repeat (12) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // input bubbles
    for (int i = 0; i < 12; i++) begin
      send_rand();
      @(posedge clk);
      #1;
    end
    drain();

    // reset mid-frame with pixels in flight
    for (int i = 0; i < 6; i++) send_rand();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.threshold = 8'd20;
    for (int i = 0; i < 4; i++) send_rand();
    drain();

    // random stress: random gaps, random backpressure, threshold churn
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          bus.threshold = 8'($urandom);
          send_rand();
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        stim_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!stim_done && k < 5000) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 2) != 0);
          k++;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
